auxiliary_video_information_info_frame_receiver: RTL

//  Sink-side AVI InfoFrame receiver. Deserialises one 32-cycle data-island packet from the TERC4 decoder
//  and checks the BCH parity of the header and subpackets. It then checks the type, version, length and

---
 rtl/hdmi_infoframe_pkg.sv | 40 ++++
 rtl/hdmi_bch_check.sv | 37 +++
 rtl/auxiliary_video_information_info_frame_receiver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hdmi_infoframe_pkg.sv
// Shared types and constants for the AVI InfoFrame receiver.
package hdmi_infoframe_pkg;

    localparam logic [7:0] AVI_HB0     = 8'h82;
    localparam logic [7:0] AVI_VERSION = 8'h02;
    localparam logic [4:0] AVI_LENGTH  = 5'd13;

    // G(x) = 1 + x^6 + x^7 + x^8 in bit-reversed form for an LSB-first shift-right LFSR
    localparam logic [7:0] BCH_POLY = 8'b1000_0011;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK
    } avi_state_t;

    typedef struct packed {
        logic [1:0] video_format;
        logic       afi_present;
        logic [1:0] bar_info;
        logic [1:0] scan_info;
        logic [1:0] colorimetry;
        logic [1:0] picture_aspect;
        logic [3:0] active_aspect;
        logic       it_content;
        logic [2:0] ext_colorimetry;
        logic [1:0] rgb_quant;
        logic [1:0] nups;
        logic [6:0] vic;
        logic [1:0] ycc_quant;
        logic [1:0] content_type;
        logic [3:0] pixel_repetition;
    } avi_fields_t;

    // One serial BCH step: advance the parity register by one data bit
    function automatic logic [7:0] bch_step(input logic [7:0] par, input logic bit_in);
        return (par >> 1) ^ ((par[0] ^ bit_in) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_check.sv
// Serial BCH parity generator; consumes BITS_PER_CYCLE data bits per clock, LSB first.
module hdmi_bch_check
    import hdmi_infoframe_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic                      i_enable,
    input  logic [BITS_PER_CYCLE-1:0] i_bits,
    output logic [7:0]                o_parity
);

    logic [7:0] r_parity;
    logic [7:0] w_next;

    // Next parity: a start cycle restarts from zero and already folds in its own bits
    always_comb begin
        w_next = i_start ? 8'h00 : r_parity;
        for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
            w_next = bch_step(w_next, i_bits[b]);
        end
    end

    // Parity register; frozen once the data bits of the block have been consumed
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_parity <= '0;
        end else if (i_start || i_enable) begin
            r_parity <= w_next;
        end
    end

    assign o_parity = r_parity;

endmodule

// File: rtl/auxiliary_video_information_info_frame_receiver.sv
// Sink-side AVI InfoFrame receiver: collects a 32-cycle data-island packet,
// checks BCH parity, header and checksum, and latches the AVI fields.
module auxiliary_video_information_info_frame_receiver
    import hdmi_infoframe_pkg::*;
#(
    parameter int unsigned CHECK_BCH = 1,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        packet_enable,
    input  logic [8:0]  packet_data,
    output avi_fields_t avi_fields,
    output logic        avi_valid,
    output logic        avi_update,
    output logic        bch_error,
    output logic        checksum_error
);

    avi_state_t  r_state;
    avi_state_t  w_next_state;
    logic [4:0]  r_count;
    logic [31:0] r_hdr;
    logic [63:0] r_sub [4];

    logic        w_capture;
    logic [4:0]  w_idx;
    logic        w_hdr_en;
    logic        w_sub_en;
    logic [7:0]  w_hdr_par;
    logic [7:0]  w_sub_par [4];
    logic [7:0]  w_sum;
    logic        w_bch_bad;
    logic        w_is_avi;
    logic        w_accept;
    logic        w_in_check;
    logic        w_unused;

    // Any packet_enable starts a packet at bit 0, including an abort mid-COLLECT
    assign w_capture = packet_enable || (r_state == COLLECT);
    assign w_idx     = packet_enable ? 5'd0 : r_count;
    assign w_hdr_en  = w_capture && (w_idx < 5'd24);
    assign w_sub_en  = w_capture && (w_idx < 5'd28);

    // State register
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (packet_enable) w_next_state = COLLECT;
            COLLECT: begin
                if (packet_enable)            w_next_state = COLLECT;
                else if (r_count == 5'd31)    w_next_state = CHECK;
            end
            CHECK:   w_next_state = packet_enable ? COLLECT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bit counter and packet capture; count wraps to 0 after bit 31
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_hdr   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_sub[i] <= '0;
            end
        end else if (w_capture) begin
            r_count        <= w_idx + 5'd1;
            r_hdr[w_idx]   <= packet_data[0];
            for (int unsigned i = 0; i < 4; i++) begin
                r_sub[i][{w_idx, 1'b0}] <= packet_data[2*i+1];
                r_sub[i][{w_idx, 1'b1}] <= packet_data[2*i+2];
            end
        end
    end

    hdmi_bch_check #(.BITS_PER_CYCLE(1)) u_bch_hdr (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .i_start   (packet_enable),
        .i_enable  (w_hdr_en),
        .i_bits    (packet_data[0]),
        .o_parity  (w_hdr_par)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_bch
        hdmi_bch_check #(.BITS_PER_CYCLE(2)) u_bch_sub (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .i_start   (packet_enable),
            .i_enable  (w_sub_en),
            .i_bits    (packet_data[2*gi+2 -: 2]),
            .o_parity  (w_sub_par[gi])
        );
    end

    // Checksum over HB0..HB2 and PB0..PB13, plus BCH comparison for all five blocks
    always_comb begin
        w_sum = r_hdr[7:0] + r_hdr[15:8] + r_hdr[23:16];
        for (int unsigned k = 0; k < 7; k++) begin
            w_sum = w_sum + r_sub[0][8*k +: 8] + r_sub[1][8*k +: 8];
        end
        w_bch_bad = (w_hdr_par != r_hdr[31:24]);
        for (int unsigned i = 0; i < 4; i++) begin
            w_bch_bad = w_bch_bad | (w_sub_par[i] != r_sub[i][63:56]);
        end
    end

    assign w_in_check = (r_state == CHECK);
    assign w_is_avi   = (r_hdr[7:0] == AVI_HB0) && (r_hdr[15:8] == AVI_VERSION)
                     && (r_hdr[20:16] == AVI_LENGTH);
    assign w_accept   = w_is_avi && (w_sum == 8'd0) && !((CHECK_BCH != 0) && w_bch_bad);

    // Registered result pulses and field latch, one clock after CHECK
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            avi_fields     <= '0;
            avi_valid      <= 1'b0;
            avi_update     <= 1'b0;
            bch_error      <= 1'b0;
            checksum_error <= 1'b0;
        end else begin
            avi_update     <= w_in_check && w_accept;
            bch_error      <= w_in_check && w_bch_bad;
            checksum_error <= w_in_check && w_is_avi && (w_sum != 8'd0);
            if (w_in_check && w_accept) begin
                avi_fields <= {r_sub[0][14:8], r_sub[0][23:16], r_sub[0][31:24],
                               r_sub[0][38:32], r_sub[0][47:40]};
                avi_valid  <= 1'b1;
            end
        end
    end

    // Subpackets 2/3 only contribute parity; TIMEOUT is reserved and fixed
    assign w_unused = ^{r_sub[2][55:0], r_sub[3][55:0], 8'(TIMEOUT)};

endmodule
